// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side drain controller.
// Holds the FSM encoding, skid depth and a pointer wrap helper.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 3;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/skid_buf3.sv
// Three-entry circular register buffer absorbing FIFO read latency.
// Head entry is presented combinationally; flush empties it at once.
module skid_buf3
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic [1:0]       head;
    logic [1:0]       tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (wr) begin
                mem[tail] <= wdata;
                tail      <= ptr_inc(tail);
            end
            if (pop) head <= ptr_inc(head);
            occ <= occ + {1'b0, wr} - {1'b0, pop};
        end
    end

    assign rdata = mem[head];

endmodule

// File: rtl/fifo_drain.sv
// Pops a burst of len words from a FIFO and streams them with last.
// Optional burst abort is enabled by defining FIFO_DRAIN_ABORT_EN.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LEN_BIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_BIT-1:0] len,
    output logic               busy,
    output logic               done,
    output logic               fifo_ren,
    input  logic               fifo_empty,
    input  logic [WIDTH-1:0]   fifo_dout,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
`ifdef FIFO_DRAIN_ABORT_EN
    input  logic               abort,
`endif
    output logic               m_last
);

    state_t             state;
    logic [LEN_BIT-1:0] issue_rem;
    logic [LEN_BIT-1:0] out_rem;
    logic               inflight;
    logic               aborting;
    logic               abort_now;
    logic               stop;
    logic               pop;
    logic               wr;
    logic [1:0]         occ;
    logic [2:0]         fill;

`ifdef FIFO_DRAIN_ABORT_EN
    assign abort_now = (state == RUN) & abort;
`else
    assign abort_now = 1'b0;
`endif

    assign stop = abort_now | aborting;
    assign pop  = m_valid & m_ready;
    assign wr   = inflight & ~stop;

    // Projected occupancy after this cycle, counting the word in flight.
    assign fill = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    assign fifo_ren = (state == RUN) & ~fifo_empty & ~stop
                    & (issue_rem != '0) & (fill < 3'd3);

    skid_buf3 #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .flush (stop),
        .wr    (wr),
        .wdata (fifo_dout),
        .pop   (pop),
        .rdata (m_data),
        .occ   (occ)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            issue_rem <= '0;
            out_rem   <= '0;
            inflight  <= 1'b0;
            aborting  <= 1'b0;
        end else begin
            inflight <= fifo_ren;
            if (fifo_ren) issue_rem <= issue_rem - 1'b1;
            if (pop)      out_rem   <= out_rem - 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        issue_rem <= len;
                        out_rem   <= len;
                        state     <= (len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (pop & m_last)         state    <= DONE;
                    else if (stop & ~inflight) state   <= DONE;
                    else if (stop)            aborting <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    aborting <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign m_valid = (occ != 2'd0);
    assign m_last  = (out_rem == LEN_BIT'(1));

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain against a queue-based FIFO model.
// Table vectors, hand-written corner sequences and randomized bursts.
module tb_fifo_drain;

    localparam int W  = 8;
    localparam int LB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LB-1:0] len = '0;
    logic          busy, done, fifo_ren, fifo_empty;
    logic [W-1:0]  fifo_dout = '0;
    logic [W-1:0]  m_data;
    logic          m_valid, m_last;
    logic          m_ready = 1'b0;
`ifdef FIFO_DRAIN_ABORT_EN
    logic          abort = 1'b0;
`endif

    always #5 clk = ~clk;

    fifo_drain #(.WIDTH(W), .LEN_BIT(LB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_ren   (fifo_ren),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
`ifdef FIFO_DRAIN_ABORT_EN
        .abort      (abort),
`endif
        .m_last     (m_last)
    );

    // Attached FIFO model with one-cycle registered read data.
    logic [W-1:0] mem [256];
    int           wp = 0;
    int           rp = 0;
    logic         fifo_clr = 1'b0;
    int           ren_cnt = 0;
    int           ren_viol = 0;

    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rp <= wp;
        end else if (fifo_ren) begin
            fifo_dout <= mem[rp[7:0]];
            rp <= rp + 1;
        end
        if (fifo_ren) ren_cnt <= ren_cnt + 1;
        if (fifo_ren && fifo_empty) ren_viol <= ren_viol + 1;
    end

    int           vecs = 0;
    int           errs = 0;
    logic [W-1:0] exp_q [$];
    int           cur_len, delivered, cyc;
    int           first_valid, done_cyc, busy_bad, ren_base;
    bit           prev_stall;
    logic [W-1:0] prev_data;

    typedef struct {
        int len;
        int mode;
        int exp_done;
        int exp_first;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        mem[wp[7:0]] = d;
        wp = wp + 1;
        exp_q.push_back(d);
    endtask

    task automatic flush();
        @(negedge clk);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        exp_q.delete();
        prev_stall = 0;
    endtask

    task automatic begin_burst(input int L);
        @(negedge clk);
        start = 1'b1;
        len = L[LB-1:0];
        cur_len = L;
        delivered = 0;
        cyc = 0;
        first_valid = -1;
        done_cyc = -1;
        busy_bad = 0;
        prev_stall = 0;
        ren_base = ren_cnt;
    endtask

    task automatic step(input bit rdy, input bit do_push);
        @(negedge clk);
        start = 1'b0;
        m_ready = rdy;
        cyc++;
        if (do_push) push(8'($urandom));
        #1;
        if (busy !== 1'b1 && done_cyc < 0) busy_bad++;
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (prev_stall) chk("hold_data", 32'(m_data), 32'(prev_data));
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("extra_word", 1, 0);
            else chk("data", 32'(m_data), 32'(exp_q.pop_front()));
            chk("last", 32'(m_last), 32'(delivered + 1 == cur_len));
            delivered++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data = m_data;
        if (done && done_cyc < 0) done_cyc = cyc;
    endtask

    function automatic bit rdy_of(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 3) == 0;
        return 1'($urandom % 2);
    endfunction

    task automatic run(input int L, input int mode, input bit rnd_push);
        bit p;
        begin_burst(L);
        for (int k = 0; k < 300 && done_cyc < 0; k++) begin
            p = rnd_push && ($urandom % 2 == 1)
              && (exp_q.size() < cur_len - delivered);
            step(rdy_of(mode, cyc + 1), p);
        end
    endtask

    task automatic finish_burst(input string nm, input int words);
        chk({nm, "_done_seen"}, 32'(done_cyc >= 0), 1);
        chk({nm, "_words"}, delivered, words);
        chk({nm, "_ren_pulses"}, ren_cnt - ren_base, words);
        chk({nm, "_busy"}, busy_bad, 0);
        step(1'b1, 1'b0);
        chk({nm, "_idle"}, {30'd0, busy, done}, 0);
    endtask

    initial begin
        vec_t tbl [6];
        int L;
        int pre;
        int a;

        tbl[0] = '{5, 0, 8, 3};
        tbl[1] = '{1, 0, 4, 3};
        tbl[2] = '{2, 0, 5, 3};
        tbl[3] = '{0, 0, 1, -1};
        tbl[4] = '{7, 0, 10, 3};
        tbl[5] = '{4, 1, 13, 3};

        #2 rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ren", 32'(fifo_ren), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_data", 32'(m_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            flush();
            for (int w = 1; w <= tbl[i].len; w++) push(8'(w));
            run(tbl[i].len, tbl[i].mode, 1'b0);
            chk("tbl_first_valid", first_valid, tbl[i].exp_first);
            chk("tbl_done_cycle", done_cyc, tbl[i].exp_done);
            finish_burst("tbl", tbl[i].len);
        end

        flush();
        for (int w = 0; w < 8; w++) push(8'(8'h40 + w));
        begin_burst(8);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_ren", 32'(fifo_ren), 0);
        chk("midrst_valid", 32'(m_valid), 0);
        chk("midrst_last", 32'(m_last), 0);
        chk("midrst_data", 32'(m_data), 0);
        @(negedge clk);
        rst = 1'b1;
        flush();
        for (int w = 0; w < 3; w++) push(8'(8'hA0 + w));
        run(3, 0, 1'b0);
        chk("postrst_done_cycle", done_cyc, 6);
        finish_burst("postrst", 3);

        flush();
        push(8'h11);
        push(8'h22);
        begin_burst(4);
        for (int k = 0; k < 20 && delivered < 2; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0);
            chk("under_valid", 32'(m_valid), 0);
            chk("under_ren", 32'(fifo_ren), 0);
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int k = 0; k < 20 && done_cyc < 0; k++) step(1'b1, 1'b0);
        finish_burst("under", 4);

`ifdef FIFO_DRAIN_ABORT_EN
        flush();
        for (int w = 0; w < 8; w++) push(8'(8'h80 + w));
        begin_burst(8);
        for (int k = 0; k < 20 && delivered < 2; k++) step(1'b1, 1'b0);
        @(posedge clk);
        #1 abort = 1'b1;
        step(1'b0, 1'b0);
        a = cyc;
        chk("abort_ren", 32'(fifo_ren), 0);
        @(posedge clk);
        #1 abort = 1'b0;
        step(1'b1, 1'b0);
        chk("abort_valid", 32'(m_valid), 0);
        chk("abort_ren_after", 32'(fifo_ren), 0);
        for (int k = 0; k < 4 && done_cyc < 0; k++) step(1'b1, 1'b0);
        chk("abort_done_soon", 32'(done_cyc > 0 && done_cyc <= a + 2), 1);
        chk("abort_lost", 32'(ren_cnt - ren_base - delivered <= 2), 1);
        step(1'b1, 1'b0);
        chk("abort_idle", {30'd0, busy, m_valid}, 0);
`endif

        flush();
        for (int b = 0; b < 25; b++) begin
            L = $urandom_range(0, 12);
            pre = $urandom_range(0, L);
            @(negedge clk);
            for (int w = 0; w < pre; w++) push(8'($urandom));
            run(L, 2, 1'b1);
            finish_burst("rnd", L);
        end

        chk("ren_while_empty", ren_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
